// File: rtl/fec_pkg.sv
// rtl/fec_pkg.sv - shared KR FEC constants, frame state encoding and parity division step
package fec_pkg;

   localparam int                FEC_BLKS_PER_FRAME = 32;
   localparam int                FEC_PARITY_W       = 32;
   localparam int                FEC_BLK_W          = 65;
   localparam int                FEC_CNT_W          = 5;
   localparam logic [31:0]       FEC_POLY           = 32'h00A0_0805;
   localparam logic [57:0]       FEC_PN_SEED        = 58'h3FF_FFFF_FFFF_FFFF;
   localparam logic [FEC_CNT_W-1:0] FEC_LAST_BLK    = FEC_CNT_W'(FEC_BLKS_PER_FRAME - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DATA = 2'd1,
      S_PAR  = 2'd2
   } fec_state_e;

   // Shifts the block into the remainder MSB first; the receive syndrome path uses the same step.
   function automatic logic [FEC_PARITY_W-1:0] lfsr_next(input logic [FEC_PARITY_W-1:0] parity,
                                                          input logic [FEC_BLK_W-1:0]    blk);
      logic [FEC_PARITY_W-1:0] p;
      logic                    fb;
      p = parity;
      for (int i = FEC_BLK_W - 1; i >= 0; i--) begin
         fb = p[FEC_PARITY_W-1];
         p  = {p[FEC_PARITY_W-2:0], blk[i]};
         if (fb) p = p ^ FEC_POLY;
      end
      return p;
   endfunction

endpackage

// File: rtl/fec_encoder_insert_parity_lfsr.sv
// rtl/fec_encoder_insert_parity_lfsr.sv - fec_parity_lfsr: unrolled 65-bit division step and parity register
module fec_parity_lfsr
   import fec_pkg::*;
(
   input  logic                    CLK,
   input  logic                    RST_N,
   input  logic                    CLR,
   input  logic                    ADV,
   input  logic [FEC_BLK_W-1:0]    BLK,
   output logic [FEC_PARITY_W-1:0] PARITY
);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         PARITY <= '0;
      end else if (CLR) begin
         PARITY <= '0;
      end else if (ADV) begin
         PARITY <= lfsr_next(PARITY, BLK);
      end
   end

endmodule

// File: rtl/fec_encoder_insert.sv
// rtl/fec_encoder_insert.sv - KR FEC Tx encoder, 32 data words + 1 parity word; FEC_SCRAMBLE_EN adds PN-2112 scrambling
module fec_encoder_insert
   import fec_pkg::*;
(
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic                 FEC_ENA,
   input  logic                 T_BLK_ENA,
   input  logic [FEC_BLK_W-1:0] T_BLK,
   output logic                 T_BLK_RDY,
   output logic                 E_BLK_ENA,
   output logic [FEC_BLK_W-1:0] E_BLK,
   output logic                 E_BLK_PAR,
   output logic                 CSR_STAT_UNDERRUN
);

   fec_state_e              state;
   fec_state_e              state_nxt;
   logic [FEC_CNT_W-1:0]    blk_cnt;
   logic                    accept;
   logic                    last_blk;
   logic [FEC_PARITY_W-1:0] parity;
   logic [FEC_BLK_W-1:0]    pn_mask;

   assign T_BLK_RDY = (state == S_DATA);
   assign accept    = T_BLK_RDY & T_BLK_ENA;
   assign last_blk  = (blk_cnt == FEC_LAST_BLK);

   fec_parity_lfsr u_parity (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .CLR    (!FEC_ENA || state == S_PAR),
      .ADV    (accept & FEC_ENA),
      .BLK    (T_BLK),
      .PARITY (parity)
   );

   always_comb begin
      state_nxt = state;
      if (!FEC_ENA) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE:  state_nxt = S_DATA;
            S_DATA:  if (accept && last_blk) state_nxt = S_PAR;
            S_PAR:   state_nxt = S_DATA;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state   <= S_IDLE;
         blk_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (!FEC_ENA) begin
            blk_cnt <= '0;
         end else if (accept) begin
            blk_cnt <= last_blk ? '0 : blk_cnt + 1'b1;
         end
      end
   end

`ifdef FEC_SCRAMBLE_EN
   logic [57:0] pn_state;
   logic [57:0] pn_adv;

   // 65 sequence bits per word, first bit lands on word bit 64.
   always_comb begin
      logic pn_bit;
      pn_adv  = pn_state;
      pn_mask = '0;
      for (int i = FEC_BLK_W - 1; i >= 0; i--) begin
         pn_bit     = pn_adv[57] ^ pn_adv[38];
         pn_adv     = {pn_adv[56:0], pn_bit};
         pn_mask[i] = pn_bit;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         pn_state <= FEC_PN_SEED;
      end else if (!FEC_ENA || state != S_DATA) begin
         pn_state <= FEC_PN_SEED;
      end else if (accept) begin
         pn_state <= pn_adv;
      end
   end
`else
   assign pn_mask = '0;
`endif

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         E_BLK_ENA         <= 1'b0;
         E_BLK             <= '0;
         E_BLK_PAR         <= 1'b0;
         CSR_STAT_UNDERRUN <= 1'b0;
      end else if (!FEC_ENA) begin
         E_BLK_ENA         <= 1'b0;
         E_BLK             <= '0;
         E_BLK_PAR         <= 1'b0;
         CSR_STAT_UNDERRUN <= 1'b0;
      end else begin
         E_BLK_ENA <= 1'b0;
         E_BLK_PAR <= 1'b0;
         case (state)
            S_DATA: begin
               if (accept) begin
                  E_BLK_ENA <= 1'b1;
                  E_BLK     <= T_BLK ^ pn_mask;
               end else begin
                  CSR_STAT_UNDERRUN <= 1'b1;
               end
            end
            S_PAR: begin
               // Upper 33 sequence bits are dropped so the pad stays zero on the line.
               E_BLK_ENA <= 1'b1;
               E_BLK_PAR <= 1'b1;
               E_BLK     <= {33'h0, parity ^ pn_mask[FEC_PARITY_W-1:0]};
            end
            default: ;
         endcase
      end
   end

endmodule
